// File: rtl/mem_stage_if.sv
// EX/MEM request, data-cache and MEM/WB signals of the memory stage.
// master: the side driving the stage (upstream and cache); slave: mem_stage.
interface mem_stage_if;
  logic        valid_i;
  logic        dREN_i;
  logic        dWEN_i;
  logic [31:0] addr_i;
  logic [31:0] store_i;
  logic [31:0] alu_i;
  logic [4:0]  wsel_i;
  logic        RegWr_i;
  logic        MemToReg_i;
  logic        halt_i;
  logic        flush_i;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        wb_valid_o;
  logic [31:0] wdat_o;
  logic [4:0]  wsel_o;
  logic        RegWr_o;
  logic        halt_o;
  logic [31:0] dmemload_o;
  logic        mem_stall_o;
  logic        err_o;

  modport master (
    output valid_i, dREN_i, dWEN_i, addr_i, store_i, alu_i, wsel_i, RegWr_i,
           MemToReg_i, halt_i, flush_i, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, wb_valid_o, wdat_o, wsel_o,
           RegWr_o, halt_o, dmemload_o, mem_stall_o, err_o
  );

  modport slave (
    input  valid_i, dREN_i, dWEN_i, addr_i, store_i, alu_i, wsel_i, RegWr_i,
           MemToReg_i, halt_i, flush_i, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, wb_valid_o, wdat_o, wsel_o,
           RegWr_o, halt_o, dmemload_o, mem_stall_o, err_o
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: non-memory ops pass straight through; loads/stores run a
// blocking IDLE -> ACCESS -> DONE handshake with the data cache and a timeout.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic        CLK,
  input logic        nRST,
  mem_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  wsel;
    logic        regwr;
    logic        m2r;
    logic        halt;
  } wb_cap_t;

  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  state_t      state;
  wb_cap_t     cap;
  logic [31:0] load_q, addr_q, store_q;
  logic        ren_q, wen_q;
  logic [7:0]  cnt, cnt_inc;
  logic        kill, halted, err, tmo_q;

  logic        memop, start, tmo;
  logic        wb_valid, regwr_out, halt_out, stall;
  logic [31:0] wdat, load_out;
  logic [4:0]  wsel_out;

  assign memop   = bus.valid_i & (bus.dREN_i | bus.dWEN_i) & ~bus.flush_i;
  assign start   = (state == IDLE) && memop && !halted;
  assign cnt_inc = cnt + 8'd1;
  // dhit wins over a timeout landing in the same cycle
  assign tmo     = (state == ACCESS) && !bus.dhit && (cnt_inc == TMO_LIM);

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state   <= IDLE;
      cap     <= '0;
      load_q  <= '0;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      cnt     <= '0;
      kill    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cap     <= '{alu: bus.alu_i, wsel: bus.wsel_i, regwr: bus.RegWr_i,
                         m2r: bus.MemToReg_i, halt: bus.halt_i};
            ren_q   <= bus.dREN_i & ~bus.dWEN_i;
            wen_q   <= bus.dWEN_i;
            addr_q  <= bus.addr_i;
            store_q <= bus.dWEN_i ? bus.store_i : '0;
            cnt     <= '0;
            kill    <= 1'b0;
            tmo_q   <= 1'b0;
            state   <= ACCESS;
          end else if (wb_valid && halt_out) begin
            halted <= 1'b1;
          end
        end
        ACCESS: begin
          // a flush cannot abort the cache access, it only squashes writeback
          if (bus.flush_i) kill <= 1'b1;
          if (bus.dhit || tmo) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            state   <= DONE;
            if (bus.dhit) begin
              load_q <= bus.dmemload;
            end else begin
              err   <= 1'b1;
              tmo_q <= 1'b1;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          if (bus.flush_i) kill <= 1'b1;
          if (wb_valid && halt_out) halted <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    wb_valid  = 1'b0;
    wdat      = '0;
    wsel_out  = '0;
    regwr_out = 1'b0;
    halt_out  = 1'b0;
    stall     = 1'b0;
    load_out  = '0;
    case (state)
      IDLE: begin
        wb_valid  = bus.valid_i & ~bus.flush_i & ~halted & ~memop;
        wdat      = bus.alu_i;
        wsel_out  = wb_valid ? bus.wsel_i : '0;
        regwr_out = bus.RegWr_i & wb_valid;
        halt_out  = bus.halt_i & wb_valid;
        stall     = start;
      end
      ACCESS: stall = 1'b1;
      DONE: begin
        wb_valid  = ~(kill | bus.flush_i);
        wdat      = cap.m2r ? load_q : cap.alu;
        load_out  = load_q;
        wsel_out  = cap.wsel;
        regwr_out = cap.regwr & ~tmo_q & wb_valid;
        halt_out  = cap.halt | tmo_q;
      end
      default: ;
    endcase
  end

  assign bus.dmemREN     = ren_q;
  assign bus.dmemWEN     = wen_q;
  assign bus.dmemaddr    = addr_q;
  assign bus.dmemstore   = store_q;
  assign bus.wb_valid_o  = wb_valid;
  assign bus.wdat_o      = wdat;
  assign bus.wsel_o      = wsel_out;
  assign bus.RegWr_o     = regwr_out;
  assign bus.halt_o      = halt_out;
  assign bus.dmemload_o  = load_out;
  assign bus.mem_stall_o = stall;
  assign bus.err_o       = err;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: pass-through vector table, cache handshake sequences,
// writeback scoreboard checked whenever wb_valid_o fires.
module tb_mem_stage;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  mem_stage_if bus();

  mem_stage #(.TIMEOUT(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] wdat;
    logic [4:0]  wsel;
    logic        regwr;
    logic        halt;
  } exp_t;

  typedef struct {
    logic        valid, ren, flush, regwr;
    logic [31:0] alu;
    logic [4:0]  wsel;
    logic        exp_wb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   wb_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!nRST && bus.wb_valid_o === 1'b1) begin
      wb_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got writeback wdat=%h, required none", bus.wdat_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_wdat", bus.wdat_o, e.wdat);
        chk("wb_wsel", 32'(bus.wsel_o), 32'(e.wsel));
        chk("wb_regwr", 32'(bus.RegWr_o), 32'(e.regwr));
        chk("wb_halt", 32'(bus.halt_o), 32'(e.halt));
      end
    end
  end

  task automatic idle_inputs();
    bus.valid_i = 0; bus.dREN_i = 0; bus.dWEN_i = 0; bus.addr_i = '0;
    bus.store_i = '0; bus.alu_i = '0; bus.wsel_i = '0; bus.RegWr_i = 0;
    bus.MemToReg_i = 0; bus.halt_i = 0; bus.flush_i = 0; bus.dhit = 0;
    bus.dmemload = '0;
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    nRST = 1'b1;
    idle_inputs();
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b0;
  endtask

  // Holds one memory instruction upstream while stalled; dhit lands in ACCESS
  // cycle n_hit (0-based), flush pulses in ACCESS cycle f_at.
  task automatic run_mem(input bit wr, input logic [31:0] addr, input logic [31:0] store,
                         input logic [31:0] alu, input logic [31:0] ldata,
                         input logic [4:0] wsel, input bit regwr, input bit m2r,
                         input int n_hit, input int f_at, input bit exp_kill,
                         input bit exp_tmo, output int stall_n, output int req_n);
    bit done;
    if (!exp_kill)
      sb.push_back('{wdat: m2r ? ldata : alu, wsel: wsel,
                     regwr: regwr & ~exp_tmo, halt: exp_tmo});
    @(posedge CLK); #1;
    bus.valid_i = 1; bus.dREN_i = !wr; bus.dWEN_i = wr; bus.addr_i = addr;
    bus.store_i = store; bus.alu_i = alu; bus.wsel_i = wsel; bus.RegWr_i = regwr;
    bus.MemToReg_i = m2r; bus.dmemload = ldata; bus.dhit = 0; bus.flush_i = 0;
    stall_n = 0; req_n = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      if (bus.mem_stall_o) stall_n++;
      if (bus.dmemREN || bus.dmemWEN) begin
        if (req_n == 0) begin
          chk("req_addr", bus.dmemaddr, addr);
          chk("req_store", bus.dmemstore, wr ? store : 32'h0);
          chk("req_dir", 32'({bus.dmemREN, bus.dmemWEN}), wr ? 32'd1 : 32'd2);
        end
        req_n++;
      end
      done = (c > 0) && !bus.mem_stall_o;
      @(posedge CLK); #1;
      bus.dhit    = !done && (req_n == n_hit);
      bus.flush_i = !done && (req_n == f_at);
    end
    chk("mem_done", 32'(done), 32'd1);
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int st, rq, wb0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 5'd3,  1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0005, 5'd2,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0006, 5'd6,  1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0007, 5'd7,  1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 5'd8,  1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 5'd0,  1'b1};

    idle_inputs();
    do_reset();
    @(negedge CLK);
    chk("rst_ren", 32'(bus.dmemREN), 0);
    chk("rst_wen", 32'(bus.dmemWEN), 0);
    chk("rst_addr", bus.dmemaddr, 0);
    chk("rst_stall", 32'(bus.mem_stall_o), 0);
    chk("rst_wb", 32'(bus.wb_valid_o), 0);
    chk("rst_err", 32'(bus.err_o), 0);

    // same-cycle pass-through for non-memory ops
    foreach (vecs[i]) begin
      @(posedge CLK); #1;
      bus.valid_i = vecs[i].valid; bus.dREN_i = vecs[i].ren; bus.flush_i = vecs[i].flush;
      bus.RegWr_i = vecs[i].regwr; bus.alu_i = vecs[i].alu; bus.wsel_i = vecs[i].wsel;
      if (vecs[i].exp_wb)
        sb.push_back('{wdat: vecs[i].alu, wsel: vecs[i].wsel, regwr: vecs[i].regwr, halt: 1'b0});
      @(negedge CLK);
      chk("vec_stall", 32'(bus.mem_stall_o), 0);
      chk("vec_wb", 32'(bus.wb_valid_o), 32'(vecs[i].exp_wb));
      chk("vec_regwr", 32'(bus.RegWr_o), 32'(vecs[i].regwr & vecs[i].exp_wb));
    end
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    chk("vec_no_req", 32'(bus.dmemREN | bus.dmemWEN), 0);

    // load, dhit in 4th ACCESS cycle, coinciding with counter reaching TIMEOUT
    wb0 = wb_cnt;
    run_mem(0, 32'h100, 32'h0, 32'h11, 32'hDEAD_BEEF, 5'd5, 1, 1, 3, -1, 0, 0, st, rq);
    chk("ld_stall", st, 5);
    chk("ld_req", rq, 4);
    chk("ld_wb", wb_cnt - wb0, 1);
    chk("ld_err", 32'(bus.err_o), 0);

    // store with immediate dhit
    wb0 = wb_cnt;
    run_mem(1, 32'h200, 32'h1234_5678, 32'h22, 32'h0, 5'd3, 0, 0, 0, -1, 0, 0, st, rq);
    chk("st_stall", st, 2);
    chk("st_req", rq, 1);
    chk("st_wb", wb_cnt - wb0, 1);

    // load, MemToReg=0 so ALU result is written back
    run_mem(0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_0001, 32'h1111_2222, 5'd31, 1, 0, 1, -1, 0, 0, st, rq);
    chk("ld2_stall", st, 3);
    chk("ld2_req", rq, 2);

    // flush mid-access: access completes, writeback squashed
    wb0 = wb_cnt;
    run_mem(0, 32'h180, 32'h0, 32'h44, 32'h55AA_55AA, 5'd7, 1, 1, 2, 1, 1, 0, st, rq);
    chk("fl_stall", st, 4);
    chk("fl_req", rq, 3);
    chk("fl_wb", wb_cnt - wb0, 0);

    // dhit never arrives: timeout after TIMEOUT cycles, forced halt
    wb0 = wb_cnt;
    run_mem(0, 32'h500, 32'h0, 32'h77, 32'h0, 5'd12, 1, 0, 99, -1, 0, 1, st, rq);
    chk("to_stall", st, 5);
    chk("to_req", rq, 4);
    chk("to_wb", wb_cnt - wb0, 1);
    chk("to_err", 32'(bus.err_o), 1);

    // halted: further memops are refused
    @(posedge CLK); #1;
    bus.valid_i = 1; bus.dREN_i = 1; bus.addr_i = 32'h600; bus.RegWr_i = 1;
    @(negedge CLK);
    chk("hlt_stall", 32'(bus.mem_stall_o), 0);
    chk("hlt_wb", 32'(bus.wb_valid_o), 0);
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    chk("hlt_no_req", 32'(bus.dmemREN), 0);
    chk("hlt_err_sticky", 32'(bus.err_o), 1);

    do_reset();
    @(negedge CLK);
    chk("rst2_err", 32'(bus.err_o), 0);

    // reset in 2nd ACCESS cycle with dhit present
    wb0 = wb_cnt;
    @(posedge CLK); #1;
    bus.valid_i = 1; bus.dREN_i = 1; bus.addr_i = 32'h300; bus.wsel_i = 5'd9;
    bus.RegWr_i = 1; bus.MemToReg_i = 1; bus.dmemload = 32'hBAD0_BAD0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b1; bus.dhit = 1; bus.valid_i = 0;
    @(negedge CLK);
    chk("rsta_ren_before", 32'(bus.dmemREN), 1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    chk("rsta_ren_after", 32'(bus.dmemREN), 0);
    chk("rsta_stall", 32'(bus.mem_stall_o), 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rsta_wb", wb_cnt - wb0, 0);

    // halt through pass-through, then nothing more writes back
    @(posedge CLK); #1;
    bus.valid_i = 1; bus.halt_i = 1; bus.alu_i = 32'h99; bus.wsel_i = 5'd4; bus.RegWr_i = 1;
    sb.push_back('{wdat: 32'h99, wsel: 5'd4, regwr: 1'b1, halt: 1'b1});
    @(negedge CLK);
    chk("halt_wb", 32'(bus.wb_valid_o), 1);
    @(posedge CLK); #1;
    bus.halt_i = 0; bus.alu_i = 32'h98;
    @(negedge CLK);
    chk("halted_wb", 32'(bus.wb_valid_o), 0);
    @(posedge CLK); #1;
    idle_inputs();

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
